// File: rtl/psu_sw_pwrgd_mon.sv
// Switched 12V rail power-good monitor: synchronizes and filters the rail power-good,
// qualifies it for the master sequencer and latches timeout / loss / illegal-enable faults.
module psu_sw_pwrgd_mon #(
    parameter int TIMEOUT_CYC = 2000,
    parameter int FILT_CYC    = 4,
    parameter int BLANK_CYC   = 16
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       ienable,
    input  logic       iFM_AUX_SW_EN,
    input  logic       iFM_S3_SW_P12V_STBY_EN,
    input  logic       iFM_S3_SW_P12V_EN,
    input  logic       iPWRGD_P12V_SW,
    input  logic       iClearFault,
    output logic       oPWRGD_P12V_SW_QUAL,
    output logic       oFault,
    output logic [1:0] oFaultCode
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_PG = 2'd1;
    localparam logic [1:0] GOOD    = 2'd2;
    localparam logic [1:0] FAULT   = 2'd3;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT = 2'b01;
    localparam logic [1:0] CODE_LOST    = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL = 2'b11;

    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  FILT_LEN  = 8'(FILT_CYC);
    localparam logic [7:0]  BLANK_LEN = 8'(BLANK_CYC);

    logic        req;
    logic        illegal;
    logic        auxRise;
    logic        pgSync_p0;
    logic        pgSync_p1;
    logic [7:0]  filtCnt;
    logic        pgF;
    logic [1:0]  state;
    logic [1:0]  faultCode;
    logic [15:0] toCnt;
    logic [7:0]  blankCnt;
    logic        auxPrev;

    assign req     = iFM_AUX_SW_EN | iFM_S3_SW_P12V_STBY_EN | iFM_S3_SW_P12V_EN;
    assign illegal = iFM_AUX_SW_EN & iFM_S3_SW_P12V_STBY_EN;
    assign auxRise = iFM_AUX_SW_EN & ~auxPrev;

    // Stage p0/p1: two-flop synchronizer, then the consecutive-high filter
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            pgSync_p0 <= 1'b0;
            pgSync_p1 <= 1'b0;
            filtCnt   <= 8'd0;
            pgF       <= 1'b0;
        end else begin
            pgSync_p0 <= iPWRGD_P12V_SW;
            pgSync_p1 <= pgSync_p0;
            if (!pgSync_p1) begin
                filtCnt <= 8'd0;
                pgF     <= 1'b0;
            end else if (filtCnt < FILT_LEN) begin
                filtCnt <= filtCnt + 8'd1;
                if (filtCnt == FILT_LEN - 8'd1)
                    pgF <= 1'b1;
            end
        end
    end

    // A STBY-to-AUX handover briefly drops the rail; mask the loss for BLANK_CYC cycles
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            auxPrev  <= 1'b0;
            blankCnt <= 8'd0;
        end else begin
            auxPrev <= iFM_AUX_SW_EN;
            if (state == GOOD && auxRise)
                blankCnt <= BLANK_LEN;
            else if (blankCnt != 8'd0)
                blankCnt <= blankCnt - 8'd1;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state     <= IDLE;
            faultCode <= CODE_NONE;
            toCnt     <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (ienable && req) begin
                        state <= WAIT_PG;
                        toCnt <= 16'd0;
                    end
                end
                WAIT_PG: begin
                    if (illegal) begin
                        state     <= FAULT;
                        faultCode <= CODE_ILLEGAL;
                    end else if (!ienable || !req) begin
                        state <= IDLE;
                    end else if (pgF) begin
                        state <= GOOD;
                    end else if (toCnt == TO_LAST) begin
                        state     <= FAULT;
                        faultCode <= CODE_TIMEOUT;
                    end else begin
                        toCnt <= toCnt + 16'd1;
                    end
                end
                GOOD: begin
                    if (illegal) begin
                        state     <= FAULT;
                        faultCode <= CODE_ILLEGAL;
                    end else if (!ienable || !req) begin
                        state <= IDLE;
                    end else if (!pgF && blankCnt == 8'd0) begin
                        state     <= FAULT;
                        faultCode <= CODE_LOST;
                    end
                end
                FAULT: begin
                    // Only an explicit clear with all switch requests dropped releases the fault
                    if (iClearFault && !req) begin
                        state     <= IDLE;
                        faultCode <= CODE_NONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign oPWRGD_P12V_SW_QUAL = (state == GOOD);
    assign oFault              = (state == FAULT);
    assign oFaultCode          = faultCode;

endmodule

// File: tb/tb_psu_sw_pwrgd_mon.sv
// Directed bench for psu_sw_pwrgd_mon: a per-cycle vector table plus hand-written
// multi-cycle sequences (qualification latency, timeout, handover blanking, aborts).
module tb_psu_sw_pwrgd_mon;

    logic       iClk = 1'b0;
    logic       iRst_n = 1'b0;
    logic       ienable = 1'b0;
    logic       iFM_AUX_SW_EN = 1'b0;
    logic       iFM_S3_SW_P12V_STBY_EN = 1'b0;
    logic       iFM_S3_SW_P12V_EN = 1'b0;
    logic       iPWRGD_P12V_SW = 1'b0;
    logic       iClearFault = 1'b0;
    logic       oPWRGD_P12V_SW_QUAL;
    logic       oFault;
    logic [1:0] oFaultCode;

    int nChecks = 0;
    int nFails  = 0;

    psu_sw_pwrgd_mon #(.TIMEOUT_CYC(2000), .FILT_CYC(4), .BLANK_CYC(16)) dut (
        .iClk                   (iClk),
        .iRst_n                 (iRst_n),
        .ienable                (ienable),
        .iFM_AUX_SW_EN          (iFM_AUX_SW_EN),
        .iFM_S3_SW_P12V_STBY_EN (iFM_S3_SW_P12V_STBY_EN),
        .iFM_S3_SW_P12V_EN      (iFM_S3_SW_P12V_EN),
        .iPWRGD_P12V_SW         (iPWRGD_P12V_SW),
        .iClearFault            (iClearFault),
        .oPWRGD_P12V_SW_QUAL    (oPWRGD_P12V_SW_QUAL),
        .oFault                 (oFault),
        .oFaultCode             (oFaultCode)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        string      name;
        logic       rstn, ena, aux, stby, main, pg, clr;
        logic       expQual, expFault;
        logic [1:0] expCode;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string name, input logic q, input logic f, input logic [1:0] c);
        nChecks++;
        if (oPWRGD_P12V_SW_QUAL !== q || oFault !== f || oFaultCode !== c) begin
            nFails++;
            $display("FAIL %s: got qual=%b fault=%b code=%b, expected qual=%b fault=%b code=%b",
                     name, oPWRGD_P12V_SW_QUAL, oFault, oFaultCode, q, f, c);
        end
    endtask

    task automatic setSw(input logic ena, input logic aux, input logic stby, input logic main);
        ienable = ena;
        iFM_AUX_SW_EN = aux;
        iFM_S3_SW_P12V_STBY_EN = stby;
        iFM_S3_SW_P12V_EN = main;
    endtask

    task automatic clearFault();
        setSw(1'b1, 1'b0, 1'b0, 1'b0);
        iClearFault = 1'b1;
        tick();
        iClearFault = 1'b0;
        check("clear_to_idle", 1'b0, 1'b0, 2'b00);
    endtask

    task automatic reachGood(input string name);
        bit ok = 0;
        setSw(1'b1, 1'b0, 1'b1, 1'b0);
        iPWRGD_P12V_SW = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (oPWRGD_P12V_SW_QUAL === 1'b1) ok = 1;
        end
        nChecks++;
        if (!ok) begin
            nFails++;
            $display("FAIL %s: qual=%b after 20 cycles, expected qual=1", name, oPWRGD_P12V_SW_QUAL);
        end
        repeat (20) tick();
    endtask

    initial begin
        //           name            rstn ena aux stb mai pg clr  q  f  code
        vecs[0]  = '{"reset0",        0,  0,  0,  0,  0,  0, 0,   0, 0, 2'b00};
        vecs[1]  = '{"reset1",        0,  1,  1,  1,  0,  1, 0,   0, 0, 2'b00};
        vecs[2]  = '{"idle_to_wait",  1,  1,  1,  1,  0,  0, 0,   0, 0, 2'b00};
        vecs[3]  = '{"illegal_wait",  1,  1,  1,  1,  0,  0, 0,   0, 1, 2'b11};
        vecs[4]  = '{"clr_req_hi",    1,  1,  0,  1,  0,  0, 1,   0, 1, 2'b11};
        vecs[5]  = '{"ena_no_exit",   1,  0,  0,  1,  0,  0, 0,   0, 1, 2'b11};
        vecs[6]  = '{"clr_req_lo",    1,  0,  0,  0,  0,  0, 1,   0, 0, 2'b00};
        vecs[7]  = '{"idle_no_req",   1,  1,  0,  0,  0,  0, 0,   0, 0, 2'b00};
        vecs[8]  = '{"main_to_wait",  1,  1,  0,  0,  1,  0, 0,   0, 0, 2'b00};
        vecs[9]  = '{"wait_ena_lo",   1,  0,  0,  0,  1,  0, 0,   0, 0, 2'b00};
        vecs[10] = '{"wait_again",    1,  1,  0,  0,  1,  0, 0,   0, 0, 2'b00};
        vecs[11] = '{"wait_req_lo",   1,  1,  0,  0,  0,  0, 0,   0, 0, 2'b00};
        vecs[12] = '{"stby_to_wait",  1,  1,  0,  1,  0,  0, 0,   0, 0, 2'b00};
        vecs[13] = '{"illegal_2",     1,  1,  1,  1,  0,  0, 0,   0, 1, 2'b11};
        vecs[14] = '{"reset_fault",   0,  1,  1,  1,  0,  0, 0,   0, 0, 2'b00};
        vecs[15] = '{"post_reset",    1,  0,  0,  0,  0,  0, 0,   0, 0, 2'b00};

        #1;
        for (int i = 0; i < 16; i++) begin
            iRst_n = vecs[i].rstn;
            setSw(vecs[i].ena, vecs[i].aux, vecs[i].stby, vecs[i].main);
            iPWRGD_P12V_SW = vecs[i].pg;
            iClearFault = vecs[i].clr;
            tick();
            check(vecs[i].name, vecs[i].expQual, vecs[i].expFault, vecs[i].expCode);
        end
        iClearFault = 1'b0;

        // Qualification latency: QUAL rises exactly 7 edges after raw power-good rises
        setSw(1'b1, 1'b0, 1'b1, 1'b0);
        iPWRGD_P12V_SW = 1'b0;
        tick();
        repeat (10) tick();
        check("wait_no_pg", 1'b0, 1'b0, 2'b00);
        iPWRGD_P12V_SW = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("qual_edge%0d", e), (e == 7), 1'b0, 2'b00);
        end
        repeat (20) tick();

        // Handover with a 10-cycle dip is masked by blanking
        setSw(1'b1, 1'b1, 1'b0, 1'b0);
        iPWRGD_P12V_SW = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 10) iPWRGD_P12V_SW = 1'b1;
            check($sformatf("blank10_e%0d", e), 1'b1, 1'b0, 2'b00);
        end

        // Back to STBY (falling AUX, no blank reload), then a 20-cycle dip outlasts blanking
        setSw(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        setSw(1'b1, 1'b1, 1'b0, 1'b0);
        iPWRGD_P12V_SW = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            tick();
            if (e < 18) check($sformatf("blank20_e%0d", e), 1'b1, 1'b0, 2'b00);
            else        check("pg_lost_fault", 1'b0, 1'b1, 2'b10);
        end
        repeat (3) tick();
        check("lost_sticky", 1'b0, 1'b1, 2'b10);
        clearFault();

        // Timeout: fault at edge 2000 after WAIT_PG entry, not at 1999
        iPWRGD_P12V_SW = 1'b0;
        setSw(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("timeout_entry", 1'b0, 1'b0, 2'b00);
        repeat (1999) tick();
        check("timeout_1999", 1'b0, 1'b0, 2'b00);
        tick();
        check("timeout_2000", 1'b0, 1'b1, 2'b01);
        clearFault();

        // Illegal and power-good loss seen together: illegal wins
        reachGood("good_for_illegal");
        iPWRGD_P12V_SW = 1'b0;
        repeat (3) tick();
        check("good_before_loss", 1'b1, 1'b0, 2'b00);
        setSw(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check("illegal_and_loss", 1'b0, 1'b1, 2'b11);
        clearFault();

        // Enable abort from GOOD
        reachGood("good_for_abort");
        ienable = 1'b0;
        tick();
        check("ena_abort", 1'b0, 1'b0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
